// File: rtl/store_align_buffer.sv
// Store path: checks natural alignment, places data on the byte lanes of a 64-bit row with a byte strobe, and queues the store for data memory.
// Latency: an accepted store drives mem_req_o from the next cycle. Backpressure: st_ready_o drops while DEPTH stores are buffered.
// Optional STORE_LD_HAZARD_EN flags a load that targets a row still held in the buffer.
module store_align_buffer #(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid_i,
   output logic             st_ready_o,
   input  logic [63:0]      st_addr_i,
   input  logic [63:0]      st_data_i,
   input  logic [1:0]       st_byte_en_i,
   output logic             misalign_o,
   output logic             mem_req_o,
   input  logic             mem_gnt_i,
   output logic [63:0]      mem_addr_o,
   output logic [63:0]      mem_wr_data_o,
   output logic [7:0]       mem_wr_strb_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   input  logic             ld_valid_i,
   input  logic [63:0]      ld_addr_i,
   output logic             ld_hazard_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_misalign;

   logic [2:0]  w_off;
   logic [63:0] w_mask_data;
   logic [7:0]  w_base_strb;
   logic        w_misalign;
   entry_t      w_entry;
   logic        w_empty;
   logic        w_accept;
   logic        w_enq;
   logic        w_deq;

   always_comb begin
      w_off       = st_addr_i[2:0];
      w_mask_data = st_data_i;
      w_base_strb = 8'hFF;
      w_misalign  = |st_addr_i[2:0];
      case (st_byte_en_i)
         SZ_BYTE: begin
            w_mask_data = {56'd0, st_data_i[7:0]};
            w_base_strb = 8'h01;
            w_misalign  = 1'b0;
         end
         SZ_HALF: begin
            w_mask_data = {48'd0, st_data_i[15:0]};
            w_base_strb = 8'h03;
            w_misalign  = st_addr_i[0];
         end
         SZ_WORD: begin
            w_mask_data = {32'd0, st_data_i[31:0]};
            w_base_strb = 8'h0F;
            w_misalign  = |st_addr_i[1:0];
         end
         default: ;
      endcase
      w_entry.addr = {st_addr_i[63:3], 3'b000};
      w_entry.data = w_mask_data << {w_off, 3'b000};
      w_entry.strb = w_base_strb << w_off;
   end

   assign w_empty    = (r_cnt == '0);
   assign st_ready_o = (r_cnt < FULL_CNT);
   assign w_accept   = st_valid_i && st_ready_o;
   assign w_enq      = w_accept && !w_misalign;
   assign w_deq      = !w_empty && mem_gnt_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
         r_vld      <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_accept && w_misalign;
         if (w_enq) begin
            r_wptr        <= r_wptr + 1'b1;
            r_vld[r_wptr] <= 1'b1;
         end
         // Enqueue and dequeue never target the same slot: that needs empty or full.
         if (w_deq) begin
            r_rptr        <= r_rptr + 1'b1;
            r_vld[r_rptr] <= 1'b0;
         end
         case ({w_enq, w_deq})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_enq) begin
         r_mem[r_wptr] <= w_entry;
      end
   end

   assign misalign_o    = r_misalign;
   assign mem_req_o     = !w_empty;
   assign mem_addr_o    = w_empty ? 64'd0 : r_mem[r_rptr].addr;
   assign mem_wr_data_o = w_empty ? 64'd0 : r_mem[r_rptr].data;
   assign mem_wr_strb_o = w_empty ? 8'd0  : r_mem[r_rptr].strb;
   assign count_o       = r_cnt;
   assign empty_o       = w_empty;

`ifdef STORE_LD_HAZARD_EN
   logic [63:0] w_ld_row;
   logic        w_hit;

   // Valid bits clear only at the dequeue edge, so a store leaving this cycle still stalls the load.
   always_comb begin
      w_ld_row = {ld_addr_i[63:3], 3'b000};
      w_hit    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_mem[i].addr == w_ld_row)) begin
            w_hit = 1'b1;
         end
      end
   end

   assign ld_hazard_o = ld_valid_i && w_hit;
`else
   logic w_unused_ld;

   assign w_unused_ld = ^{ld_valid_i, ld_addr_i, r_vld};
   assign ld_hazard_o = 1'b0;
`endif

endmodule

// File: tb/tb_store_align_buffer.sv
// Scoreboarded bench for store_align_buffer: directed scenarios plus randomized traffic against a lane-level model.
module tb_store_align_buffer;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;
`ifdef STORE_LD_HAZARD_EN
   localparam bit HZ_ON = 1'b1;
`else
   localparam bit HZ_ON = 1'b0;
`endif

   typedef struct {
      logic [63:0] a;
      logic [63:0] d;
      logic [7:0]  s;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             st_valid_i;
   logic             st_ready_o;
   logic [63:0]      st_addr_i;
   logic [63:0]      st_data_i;
   logic [1:0]       st_byte_en_i;
   logic             misalign_o;
   logic             mem_req_o;
   logic             mem_gnt_i;
   logic [63:0]      mem_addr_o;
   logic [63:0]      mem_wr_data_o;
   logic [7:0]       mem_wr_strb_o;
   logic [CNT_W-1:0] count_o;
   logic             empty_o;
   logic             ld_valid_i;
   logic [63:0]      ld_addr_i;
   logic             ld_hazard_o;

   ent_t q[$];
   logic exp_mis = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   store_align_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
      .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_byte_en_i(st_byte_en_i),
      .misalign_o(misalign_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
      .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o), .mem_wr_strb_o(mem_wr_strb_o),
      .count_o(count_o), .empty_o(empty_o),
      .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_hazard_o(ld_hazard_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic bit is_mis(input logic [63:0] a, input logic [1:0] sz);
      int n;
      n = 1 << sz;
      return (int'(a[2:0]) % n) != 0;
   endfunction

   // Build the memory row byte by byte: access byte i lands in lane off+i.
   function automatic ent_t model(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
      ent_t e;
      int   n;
      int   off;
      n   = 1 << sz;
      off = int'(a[2:0]);
      e.a = a & ~64'h7;
      e.d = '0;
      e.s = '0;
      for (int i = 0; i < n; i++) begin
         e.d[(off + i) * 8 +: 8] = d[i * 8 +: 8];
         e.s[off + i] = 1'b1;
      end
      return e;
   endfunction

   // Record what the coming edge does, then move to just after that edge.
   task automatic step();
      @(negedge clk);
      #3;
      if (reset) begin
         q.delete();
         exp_mis = 1'b0;
      end else if (st_valid_i && st_ready_o) begin
         if (is_mis(st_addr_i, st_byte_en_i)) begin
            exp_mis = 1'b1;
         end else begin
            q.push_back(model(st_addr_i, st_data_i, st_byte_en_i));
            exp_mis = 1'b0;
         end
      end else begin
         exp_mis = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input logic g);
      st_valid_i   = v;
      st_addr_i    = a;
      st_data_i    = d;
      st_byte_en_i = sz;
      mem_gnt_i    = g;
      step();
   endtask

   // Monitor: compares status and head against the scoreboard, pops on each grant.
   always @(negedge clk) begin
      if (!reset) begin
         bit hz;
         hz = 1'b0;
         foreach (q[i]) if (q[i].a == (ld_addr_i & ~64'h7)) hz = 1'b1;
         chk("count", 64'(count_o), 64'(q.size()));
         chk("empty", 64'(empty_o), 64'(q.size() == 0));
         chk("req", 64'(mem_req_o), 64'(q.size() != 0));
         chk("ready", 64'(st_ready_o), 64'(q.size() < DEPTH));
         chk("misalign", 64'(misalign_o), 64'(exp_mis));
         chk("hazard", 64'(ld_hazard_o), 64'(HZ_ON && ld_valid_i && hz));
         if (q.size() == 0) begin
            chk("idle_addr", mem_addr_o, 64'd0);
            chk("idle_data", mem_wr_data_o, 64'd0);
            chk("idle_strb", 64'(mem_wr_strb_o), 64'd0);
         end else begin
            chk("head_addr", mem_addr_o, q[0].a);
            chk("head_data", mem_wr_data_o, q[0].d);
            chk("head_strb", 64'(mem_wr_strb_o), 64'(q[0].s));
            if (mem_req_o && mem_gnt_i) q.delete(0);
         end
      end
   end

   initial begin
      reset = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0;
      st_byte_en_i = '0; mem_gnt_i = 1'b0; ld_valid_i = 1'b0; ld_addr_i = '0;
      @(posedge clk);
      #1;
      repeat (3) step();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      chk("rst_ready", 64'(st_ready_o), 64'd1);
      chk("rst_req", 64'(mem_req_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_empty", 64'(empty_o), 64'd1);
      chk("rst_data", mem_wr_data_o, 64'd0);

      // Byte store to a non-zero lane, granted immediately.
      drive(1, 64'h1005, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 1);
      chk("byte_req", 64'(mem_req_o), 64'd1);
      chk("byte_addr", mem_addr_o, 64'h1000);
      chk("byte_data", mem_wr_data_o, 64'h0000_AB00_0000_0000);
      chk("byte_strb", 64'(mem_wr_strb_o), 64'h20);
      drive(0, 0, 0, 0, 1);
      chk("byte_drained", 64'(count_o), 64'd0);

      // Word store, then a misaligned half-word that must be dropped.
      drive(1, 64'h2004, 64'h1234_5678_DEAD_BEEF, 2'd2, 0);
      chk("word_data", mem_wr_data_o, 64'hDEAD_BEEF_0000_0000);
      chk("word_strb", 64'(mem_wr_strb_o), 64'hF0);
      drive(1, 64'h2003, 64'h0000_0000_0000_5555, 2'd1, 0);
      chk("half_mis", 64'(misalign_o), 64'd1);
      chk("half_count", 64'(count_o), 64'd1);
      drive(0, 0, 0, 0, 1);
      chk("mis_pulse_end", 64'(misalign_o), 64'd0);
      drive(0, 0, 0, 0, 0);

      // Fill, hold the third store off, then drain in order.
      drive(1, 64'h4000, 64'hA0A0_A0A0_A0A0_A0A0, 2'd3, 0);
      drive(1, 64'h4008, 64'hB1B1_B1B1_B1B1_B1B1, 2'd3, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 64'h4010, 64'hC2C2_C2C2_C2C2_C2C2, 2'd3, 0);
         chk("full_ready", 64'(st_ready_o), 64'd0);
         chk("full_head", mem_addr_o, 64'h4000);
      end
      drive(1, 64'h4010, 64'hC2C2_C2C2_C2C2_C2C2, 2'd3, 1);
      chk("ready_after_gnt", 64'(st_ready_o), 64'd1);
      chk("count_after_gnt", 64'(count_o), 64'd1);
      drive(1, 64'h4010, 64'hC2C2_C2C2_C2C2_C2C2, 2'd3, 1);
      repeat (3) drive(0, 0, 0, 0, 1);

      // Steady enqueue + dequeue at count 1 across pointer wrap.
      drive(1, 64'h5000, 64'h0000_0000_0000_0050, 2'd3, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 64'h5008 + 64'(i * 8), 64'h0000_0000_0000_0051 + 64'(i), 2'd3, 1);
         chk("simul_count", 64'(count_o), 64'd1);
      end
      repeat (2) drive(0, 0, 0, 0, 1);

      // Load hazard against a buffered row.
      drive(1, 64'h3008, 64'h0123_4567_89AB_CDEF, 2'd3, 0);
      ld_valid_i = 1'b1; ld_addr_i = 64'h300C;
      #1;
      chk("hz_hit", 64'(ld_hazard_o), 64'(HZ_ON));
      ld_addr_i = 64'h3010;
      #1;
      chk("hz_miss", 64'(ld_hazard_o), 64'd0);
      ld_valid_i = 1'b0;

      // Reset with stores buffered and a grant and request presented.
      drive(1, 64'h3100, 64'h1111_2222_3333_4444, 2'd3, 0);
      reset = 1'b1;
      drive(1, 64'h3200, 64'h5555_6666_7777_8888, 2'd3, 1);
      reset = 1'b0;
      chk("rst_mid_req", 64'(mem_req_o), 64'd0);
      chk("rst_mid_count", 64'(count_o), 64'd0);
      drive(0, 0, 0, 0, 0);

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         logic [63:0] a;
         a = 64'h6000 + 64'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
         ld_valid_i = 1'($urandom_range(0, 1));
         ld_addr_i  = 64'h6000 + 64'($urandom_range(0, 31));
         reset      = ($urandom_range(0, 79) == 0);
         drive(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      reset = 1'b0;
      ld_valid_i = 1'b0;
      for (int c = 0; c < 20 && q.size() != 0; c++) drive(0, 0, 0, 0, 1);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d stores left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
